serial_adder_thirtytwo: RTL
===========================

// Module: serial_adder_thirtyTwo
// PURPOSE
//   Multi-cycle bit-serial adder: the additive counterpart of the 32-bit ripple subtractor.
//   Computes a + b + cin one bit per clock through a single full-adder cell and a carry flip-flop.
//   Used in the datapath wherever area matters more than latency (address/offset accumulation,
//   multi-cycle ALU add path). Handshake is start/busy/done.
// PARAMETERS
//   WIDTH   32   operand and result width in bits (>= 2)
//   CNT_W   6    bit-index counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk       in   1      rising-edge clock, sole clock domain
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request; sampled only in IDLE or DONE
//   input1    in   WIDTH  operand A, latched when start is accepted
//   input2    in   WIDTH  operand B, latched when start is accepted
//   Cin       in   1      carry-in, latched when start is accepted
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse; sum/c/ovf are valid from this cycle on
//   sum       out  WIDTH  registered result A+B+Cin mod 2**WIDTH
//   c         out  1      registered carry-out of the MSB
//   ovf       out  1      registered signed overflow flag
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, sum=0, c=0, ovf=0; operand regs, carry reg, counter = 0.
//   Reset wins over every other input in the same cycle; reset during RUN aborts, no done pulse.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 -> latch input1/input2/Cin into shift regs A,B and carry reg; clear counter;
//     clear sum; go RUN. start=0 -> stay.
//   - RUN: each cycle: s = A[0]^B[0]^carry; carry <= maj(A[0],B[0],carry);
//     A,B shift right by one; s shifts into sum from the MSB end (sum <= {s, sum[WIDTH-1:1]});
//     counter++. When counter==WIDTH-1 this cycle: also c <= final carry,
//     ovf <= (a_msb==b_msb) && (s != a_msb) using the operand MSBs of that cycle; go DONE.
//   - DONE: done=1 for exactly this cycle. start=1 -> accepted as in IDLE (go RUN, no gap);
//     start=0 -> IDLE.
//   start in RUN is ignored (not queued). Operand inputs need be stable only in the accept cycle.
//   Latency: start accepted at edge T -> RUN for WIDTH cycles -> done high in cycle T+WIDTH+1.
//   Throughput: one result per WIDTH+1 cycles with back-to-back starts.
//   sum/c/ovf hold their value through IDLE until the next accepted start
//   (sum clears at accept; c/ovf update only on the final RUN cycle).
//   sum, c, ovf must match combinational {c,sum} = input1+input2+Cin exactly; wrap-around modulo 2**WIDTH.
//   busy = (state==RUN); done = (state==DONE); both purely state-decoded, glitch-free registers.
// TESTING
//   1. input1=5, input2=7, Cin=0, start pulse -> done exactly 33 cycles later; sum=12, c=0, ovf=0.
//   2. input1=32'hFFFF_FFFF, input2=0, Cin=1 -> sum=0, c=1, ovf=0 (unsigned wrap).
//   3. input1=32'h7FFF_FFFF, input2=1, Cin=0 -> sum=32'h8000_0000, c=0, ovf=1;
//      input1=input2=32'h8000_0000 -> sum=0, c=1, ovf=1.
//   4. start re-pulsed with new operands at RUN cycle 10 -> ignored; result equals first operands,
//      busy stays high 32 cycles, single done pulse.
//   5. reset asserted at RUN cycle 16 -> next cycle busy=0, done=0, sum=0, c=0, ovf=0; no done pulse
//      follows; subsequent start 3+4 -> sum=7.
//   6. start held high continuously with changing operands -> done every 33 cycles, each result
//      matches operands present in the preceding DONE (or initial IDLE) cycle; 1000 random vectors
//      vs. reference model input1+input2+Cin.

Source files
------------

// File: rtl/serial_adder_thirtytwo_if.sv
// Start/busy/done bus of the bit-serial adder: operands and request in, status and result out.
// Handshake: start is sampled only while the adder is idle or in its done cycle; busy is high
// while bits are being added; done pulses for one cycle and sum/c/ovf hold until the next accept.
interface serial_adder_thirtytwo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic             ovf;

  modport master (
    output start, input1, input2, Cin,
    input  busy, done, sum, c, ovf
  );

  modport slave (
    input  start, input1, input2, Cin,
    output busy, done, sum, c, ovf
  );
endinterface

// File: rtl/serial_adder_thirtytwo.sv
// Bit-serial adder: one full-adder cell and a carry flop compute input1+input2+Cin,
// LSB first, one bit per clock, with carry-out and signed overflow on the last bit.
module serial_adder_thirtytwo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  serial_adder_thirtytwo_if.slave    bus,
  output logic [1:0]                 o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;

  // Single full-adder cell operating on the current LSBs of the shifting operands.
  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_a     <= bus.input1;
            r_b     <= bus.input2;
            r_carry <= bus.Cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          // On the last bit r_a[0]/r_b[0] are the original operand sign bits.
          if (w_last) begin
            r_c     <= w_cout;
            r_ovf   <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum     = r_sum;
  assign bus.c       = r_c;
  assign bus.ovf     = r_ovf;
  assign o_dbg_state = r_state;

endmodule
